tc_timer_compare: RTL

- Consumer of the 64-bit free-running time value produced by the design's time source.
- Holds a 64-bit compare register programmed over a simple 32-bit register port.
- Raises a level timer interrupt when time reaches the compare value, in one-shot or periodic (auto-reload) mode.
- Sits between the time source and the core's interrupt/CSR logic, providing mtimecmp-style behaviour.

---
 rtl/tc_timer_compare_pkg.sv | 11 +
 rtl/tc_timer_regfile.sv | 62 ++++++
 rtl/tc_timer_compare.sv | 70 +++++++
 3 files changed

// File: rtl/tc_timer_compare_pkg.sv
// tc_timer_compare_pkg: register map, CTRL bit positions and FSM state type shared by the timer compare block
package tc_timer_compare_pkg;
    localparam logic [1:0] ADDR_CMP_LO = 2'd0;
    localparam logic [1:0] ADDR_CMP_HI = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_PER  = 1;
    localparam int CTRL_PEND = 2;
    typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;
endpackage

// File: rtl/tc_timer_regfile.sv
// tc_timer_regfile: register decode, CMP_LO staging, CTRL/PERIOD storage, pending W1C and registered readback
// Ports: clk/rst; wr_en/wr_addr/wr_data and rd_en/rd_addr/rd_data register port;
//        cmp (live compare value for readback), hit_set (hardware set of pending);
//        enable/periodic/pending/period to the FSM; cmp_commit/cmp_new/w1c events to the FSM.
module tc_timer_regfile
    import tc_timer_compare_pkg::*;
#(
    parameter logic [63:0] RESET_CMP    = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter logic [31:0] RESET_PERIOD = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [1:0]  rd_addr,
    input  logic [63:0] cmp,
    input  logic        hit_set,
    output logic [31:0] rd_data,
    output logic [31:0] period,
    output logic        enable,
    output logic        periodic,
    output logic        pending,
    output logic        cmp_commit,
    output logic [63:0] cmp_new,
    output logic        w1c
);
    logic [31:0] lo_stage;
    logic [31:0] rd_mux;
    logic        wr_ctrl;
    assign wr_ctrl    = wr_en && wr_addr == ADDR_CTRL;
    assign cmp_commit = wr_en && wr_addr == ADDR_CMP_HI;
    assign cmp_new    = {wr_data, lo_stage};
    assign w1c        = wr_ctrl && wr_data[CTRL_PEND];
    // CMP_LO reads the committed compare value, never the staging register
    always_comb begin
        rd_mux = rd_addr == ADDR_CMP_LO ? cmp[31:0] :
                 rd_addr == ADDR_CMP_HI ? cmp[63:32] :
                 rd_addr == ADDR_CTRL   ? {29'b0, pending, periodic, enable} : period;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_stage <= RESET_CMP[31:0];
            period   <= RESET_PERIOD;
            enable   <= 1'b0;
            periodic <= 1'b0;
            pending  <= 1'b0;
            rd_data  <= 32'd0;
        end else begin
            if (wr_en && wr_addr == ADDR_CMP_LO) lo_stage <= wr_data;
            if (wr_en && wr_addr == ADDR_PERIOD) period <= wr_data;
            if (wr_ctrl) begin
                enable   <= wr_data[CTRL_EN];
                periodic <= wr_data[CTRL_PER];
            end
            // a hardware hit beats a simultaneous software clear
            pending <= hit_set ? 1'b1 : w1c ? 1'b0 : pending;
            if (rd_en) rd_data <= rd_mux;
        end
    end
endmodule

// File: rtl/tc_timer_compare.sv
// tc_timer_compare: mtimecmp-style 64-bit compare with one-shot or auto-reload level interrupt
// Ports: clk/rst; time_in/time_valid from the time source; wr_*/rd_* 32-bit register port
//        (0 CMP_LO, 1 CMP_HI, 2 CTRL, 3 PERIOD); irq mirrors CTRL.pending.
module tc_timer_compare
    import tc_timer_compare_pkg::*;
#(
    parameter logic [63:0] RESET_CMP    = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter logic [31:0] RESET_PERIOD = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] time_in,
    input  logic        time_valid,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [1:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        irq
);
    state_t      state;
    logic [63:0] cmp;
    logic [63:0] cmp_new;
    logic [31:0] period;
    logic        enable, periodic, pending, cmp_commit, w1c, hit, hit_set;
    assign hit     = time_valid && (time_in >= cmp);
    assign hit_set = state == ARMED && hit;
    assign irq     = pending;
    tc_timer_regfile #(
        .RESET_CMP   (RESET_CMP),
        .RESET_PERIOD(RESET_PERIOD)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .cmp       (cmp),
        .hit_set   (hit_set),
        .rd_data   (rd_data),
        .period    (period),
        .enable    (enable),
        .periodic  (periodic),
        .pending   (pending),
        .cmp_commit(cmp_commit),
        .cmp_new   (cmp_new),
        .w1c       (w1c)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmp   <= RESET_CMP;
        end else begin
            // a software commit overrides the periodic reload on the same edge
            cmp <= cmp_commit ? cmp_new : hit_set && periodic ? cmp + {32'b0, period} : cmp;
            if (!enable) state <= IDLE;
            else begin
                case (state)
                    IDLE:    state <= ARMED;
                    ARMED:   state <= hit && !periodic && !cmp_commit ? FIRED : ARMED;
                    FIRED:   state <= cmp_commit || w1c ? ARMED : FIRED;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
